// File: rtl/main_memory_responder.sv
// Block-granular main memory behind the data cache: one outstanding 128-bit read or
// write-back, fixed access latency. Optional alignment flag: MEM_ALIGN_CHECK_EN.
module main_memory_responder #(
  parameter int ACCESS_LATENCY = 4,
  parameter int NUM_BLOCKS     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [9:0]   req_addr,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_write,
  output logic [127:0] resp_rdata,
  output logic         resp_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // resp_valid and its payload hold steady until that transfer.
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef logic [127:0] mem_t [NUM_BLOCKS];

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_LATENCY - 1);

  function automatic mem_t init_mem();
    mem_t m;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      for (int w = 0; w < 4; w++) begin
        m[b][32*w +: 32] = 32'(4*b + w);
      end
    end
    return m;
  endfunction

  // Contents survive reset; only the power-up image is defined.
  mem_t mem = init_mem();

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         wr_q, wr_d;
  logic [5:0]   blk_q, blk_d;
  logic [127:0] wdata_q, wdata_d;
  logic         resp_valid_q, resp_valid_d;
  logic         resp_write_q, resp_write_d;
  logic [127:0] resp_rdata_q, resp_rdata_d;
  logic         mem_we;
  logic         blk_in_range;
  logic         accept;
  logic         commit;

  assign req_ready    = (state_q == IDLE) && rst_n;
  assign accept       = req_valid && req_ready;
  assign commit       = (state_q == BUSY) && (cnt_q == 4'd0);
  assign blk_in_range = (32'(blk_q) < NUM_BLOCKS);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    blk_d        = blk_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          wr_d    = req_write;
          blk_d   = req_addr[9:4];
          wdata_d = req_wdata;
        end
      end
      BUSY: begin
        if (commit) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_write_d = wr_q;
          if (wr_q) begin
            resp_rdata_d = '0;
            mem_we       = blk_in_range;
          end else begin
            resp_rdata_d = blk_in_range ? mem[blk_q] : '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      blk_q        <= 6'd0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      blk_q        <= blk_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // mem_we is only possible in BUSY, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[blk_q] <= wdata_q;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = resp_rdata_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic resp_err_q, resp_err_d;

  always_comb begin
    err_d      = err_q;
    resp_err_d = resp_err_q;
    if (accept) err_d = (req_addr[3:0] != 4'd0);
    if (commit) resp_err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
`else
  logic unused_addr_low;
  assign unused_addr_low = ^req_addr[3:0];
  assign resp_err        = 1'b0;
`endif

endmodule
